// File: rtl/dpram_clr.sv
// -----------------------------------------------------------------------------
// dpram_clr -- true dual-port RAM with byte enables and a built-in clear engine
//
// Two independent access ports (A and B) share one memory array on a single
// clock. A clear engine writes INIT_VAL to every word, one word per cycle.
// It runs automatically out of reset and on request. While it runs, both
// access ports are locked out.
//
// Parameters
//   DWIDTH   data width in bits (multiple of 8)
//   AWIDTH   address width, DEPTH = 2**AWIDTH
//   RDLAT    read latency in cycles (1 or 2)
//   INIT_VAL value the clear engine writes to every word
//
// Ports
//   clk, rst               single clock, synchronous active-high reset
//   clr_req                one-cycle request to start a clear (ignored if busy)
//   clr_busy               clear engine active; port accesses are ignored
//   x_en / x_we            access strobe, write (1) or read (0)   (x = a, b)
//   x_be / x_addr          byte enables, word address
//   x_wdata                write data
//   x_rdata / x_rvalid     read data (held between reads), one-cycle valid
//   coll                   one-cycle pulse after a same-address write-write
//
// Compile-time option
//   DPRAM_CLR_FWD_EN       when defined, a read on one port returns the data
//                          the other port writes to the same address in the
//                          same cycle, merged per byte. When undefined, the
//                          read returns the old contents and no forwarding
//                          logic is built.
// -----------------------------------------------------------------------------
module dpram_clr #(
    parameter int                DWIDTH   = 32,
    parameter int                AWIDTH   = 10,
    parameter int                RDLAT    = 1,
    parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  clr_busy,
    input  logic                  a_en,
    input  logic                  a_we,
    input  logic [DWIDTH/8-1:0]   a_be,
    input  logic [AWIDTH-1:0]     a_addr,
    input  logic [DWIDTH-1:0]     a_wdata,
    output logic [DWIDTH-1:0]     a_rdata,
    output logic                  a_rvalid,
    input  logic                  b_en,
    input  logic                  b_we,
    input  logic [DWIDTH/8-1:0]   b_be,
    input  logic [AWIDTH-1:0]     b_addr,
    input  logic [DWIDTH-1:0]     b_wdata,
    output logic [DWIDTH-1:0]     b_rdata,
    output logic                  b_rvalid,
    output logic                  coll
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam int NB    = DWIDTH / 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]        state;
    logic [AWIDTH-1:0] clr_cnt;
    logic [DWIDTH-1:0] mem [DEPTH];

    // ------------------------------------------------------------------------
    // Clear engine
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // in the block sees the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    // All-ones count is the last word; the counter wraps to 0.
                    if (&clr_cnt) state <= ST_IDLE;
                    clr_cnt <= clr_cnt + AWIDTH'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Reset holds the engine in CLEAR, so busy is also forced while rst is
    // high even on the first reset cycle, before the state register updates.
    assign clr_busy = rst | (state == ST_CLEAR);

    // ------------------------------------------------------------------------
    // Access qualification
    // ------------------------------------------------------------------------
    logic a_acc, b_acc;
    logic a_wr, b_wr, a_rd, b_rd;

    assign a_acc = a_en & ~clr_busy;
    assign b_acc = b_en & ~clr_busy;
    assign a_wr  = a_acc &  a_we;
    assign b_wr  = b_acc &  b_we;
    assign a_rd  = a_acc & ~a_we;
    assign b_rd  = b_acc & ~b_we;

    // ------------------------------------------------------------------------
    // Memory array
    // ------------------------------------------------------------------------
    // NOTE: the array has no reset branch; its contents are defined by the
    // clear engine, which keeps it mappable onto RAM macros.
    always_ff @(posedge clk) begin
        if (clr_busy) begin
            mem[clr_cnt] <= INIT_VAL;
        end else begin
            // Port B bytes are written first so that, on a same-address
            // collision, port A's enabled bytes override them.
            for (int i = 0; i < NB; i++) begin
                if (b_wr && b_be[i]) mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
                if (a_wr && a_be[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read word selection (with optional cross-port forwarding)
    // ------------------------------------------------------------------------
    logic [DWIDTH-1:0] a_rd_word, b_rd_word;

`ifdef DPRAM_CLR_FWD_EN
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        a_rd_word = mem[a_addr];
        b_rd_word = mem[b_addr];
        for (int i = 0; i < NB; i++) begin
            if (b_wr && b_be[i] && (b_addr == a_addr)) a_rd_word[i*8 +: 8] = b_wdata[i*8 +: 8];
            if (a_wr && a_be[i] && (a_addr == b_addr)) b_rd_word[i*8 +: 8] = a_wdata[i*8 +: 8];
        end
    end
`else
    assign a_rd_word = mem[a_addr];
    assign b_rd_word = mem[b_addr];
`endif

    // ------------------------------------------------------------------------
    // Read pipeline, stage 1
    // ------------------------------------------------------------------------
    logic              a_s1_valid, b_s1_valid;
    logic [DWIDTH-1:0] a_s1_data,  b_s1_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_s1_valid <= 1'b0;
            b_s1_valid <= 1'b0;
            a_s1_data  <= '0;
            b_s1_data  <= '0;
        end else begin
            a_s1_valid <= a_rd;
            b_s1_valid <= b_rd;
            // Data only moves on a read, so it holds between reads.
            if (a_rd) a_s1_data <= a_rd_word;
            if (b_rd) b_s1_data <= b_rd_word;
        end
    end

    // ------------------------------------------------------------------------
    // Optional stage 2 (RDLAT = 2)
    // ------------------------------------------------------------------------
    generate
        if (RDLAT == 1) begin : g_lat1
            assign a_rvalid = a_s1_valid;
            assign a_rdata  = a_s1_data;
            assign b_rvalid = b_s1_valid;
            assign b_rdata  = b_s1_data;
        end else begin : g_lat2
            logic              a_s2_valid, b_s2_valid;
            logic [DWIDTH-1:0] a_s2_data,  b_s2_data;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_s2_valid <= 1'b0;
                    b_s2_valid <= 1'b0;
                    a_s2_data  <= '0;
                    b_s2_data  <= '0;
                end else begin
                    a_s2_valid <= a_s1_valid;
                    b_s2_valid <= b_s1_valid;
                    if (a_s1_valid) a_s2_data <= a_s1_data;
                    if (b_s1_valid) b_s2_data <= b_s1_data;
                end
            end

            assign a_rvalid = a_s2_valid;
            assign a_rdata  = a_s2_data;
            assign b_rvalid = b_s2_valid;
            assign b_rdata  = b_s2_data;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Write-write collision flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) coll <= 1'b0;
        else     coll <= a_wr & b_wr & (a_addr == b_addr);
    end

endmodule

// File: tb/tb_dpram_clr.sv
// -----------------------------------------------------------------------------
// tb_dpram_clr -- self-checking bench for dpram_clr
//
// Two instances share all stimulus: d1 with RDLAT=1, d2 with RDLAT=2. A
// word-level model tracks memory contents, clear progress and the expected
// read results; every clock the outputs of both instances are compared with
// it. Scenario tasks add directed checks for specific behaviours.
// -----------------------------------------------------------------------------
module tb_dpram_clr;

    localparam int          DW    = 32;
    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] INIT  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr_req = 1'b0;
    logic        a_en = 1'b0, a_we = 1'b0, b_en = 1'b0, b_we = 1'b0;
    logic [3:0]  a_be = '0, b_be = '0;
    logic [3:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_wdata = '0, b_wdata = '0;

    logic        d1_busy, d1_a_rvalid, d1_b_rvalid, d1_coll;
    logic [31:0] d1_a_rdata, d1_b_rdata;
    logic        d2_busy, d2_a_rvalid, d2_b_rvalid, d2_coll;
    logic [31:0] d2_a_rdata, d2_b_rdata;

    always #5 clk = ~clk;

    dpram_clr #(.DWIDTH(DW), .AWIDTH(AW), .RDLAT(1), .INIT_VAL(INIT)) d1 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(d1_busy),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(d1_a_rdata), .a_rvalid(d1_a_rvalid),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(d1_b_rdata), .b_rvalid(d1_b_rvalid), .coll(d1_coll)
    );

    dpram_clr #(.DWIDTH(DW), .AWIDTH(AW), .RDLAT(2), .INIT_VAL(INIT)) d2 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(d2_busy),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(d2_a_rdata), .a_rvalid(d2_a_rvalid),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(d2_b_rdata), .b_rvalid(d2_b_rvalid), .coll(d2_coll)
    );

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    logic [31:0] m_mem [DEPTH];
    int          clr_left = 0;          // words the clear still has to write
    logic        exp_coll = 1'b0;
    logic        cur_va = 1'b0, cur_vb = 1'b0, prev_va = 1'b0, prev_vb = 1'b0;
    logic [31:0] cur_da = '0, cur_db = '0, prev_da = '0, prev_db = '0;
    logic [31:0] last1_a = '0, last1_b = '0, last2_a = '0, last2_b = '0;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        return r;
    endfunction

    // One clock: update the model from the inputs seen at the edge, then
    // compare every output of both instances.
    task automatic tick();
        bit          busy, a_acc, b_acc, a_w, b_w;
        logic [31:0] rda, rdb;
        logic        exp_busy;
        @(posedge clk);
        prev_va = cur_va; prev_da = cur_da;
        prev_vb = cur_vb; prev_db = cur_db;
        if (rst) begin
            clr_left = DEPTH;
            exp_coll = 1'b0;
            cur_va = 1'b0; cur_vb = 1'b0; prev_va = 1'b0; prev_vb = 1'b0;
            last1_a = '0; last1_b = '0; last2_a = '0; last2_b = '0;
        end else begin
            busy  = (clr_left > 0);
            a_acc = a_en && !busy;
            b_acc = b_en && !busy;
            a_w   = a_acc && a_we;
            b_w   = b_acc && b_we;
            rda   = m_mem[a_addr];
            rdb   = m_mem[b_addr];
`ifdef DPRAM_CLR_FWD_EN
            if (b_w && (b_addr == a_addr)) rda = merge(rda, b_wdata, b_be);
            if (a_w && (a_addr == b_addr)) rdb = merge(rdb, a_wdata, a_be);
`endif
            cur_va = a_acc && !a_we; cur_da = rda;
            cur_vb = b_acc && !b_we; cur_db = rdb;
            exp_coll = a_w && b_w && (a_addr == b_addr);
            if (b_w) m_mem[b_addr] = merge(m_mem[b_addr], b_wdata, b_be);
            if (a_w) m_mem[a_addr] = merge(m_mem[a_addr], a_wdata, a_be);
            if (busy) begin
                m_mem[DEPTH - clr_left] = INIT;
                clr_left--;
            end else if (clr_req) begin
                clr_left = DEPTH;
            end
        end
        if (cur_va)  last1_a = cur_da;
        if (cur_vb)  last1_b = cur_db;
        if (prev_va) last2_a = prev_da;
        if (prev_vb) last2_b = prev_db;
        exp_busy = rst || (clr_left > 0);
        #1;
        checks++; if (d1_busy !== exp_busy) begin errors++; $display("FAIL d1_clr_busy: got %0b expected %0b at %0t", d1_busy, exp_busy, $time); end
        checks++; if (d2_busy !== exp_busy) begin errors++; $display("FAIL d2_clr_busy: got %0b expected %0b at %0t", d2_busy, exp_busy, $time); end
        checks++; if (d1_coll !== exp_coll) begin errors++; $display("FAIL d1_coll: got %0b expected %0b at %0t", d1_coll, exp_coll, $time); end
        checks++; if (d2_coll !== exp_coll) begin errors++; $display("FAIL d2_coll: got %0b expected %0b at %0t", d2_coll, exp_coll, $time); end
        checks++; if (d1_a_rvalid !== cur_va) begin errors++; $display("FAIL d1_a_rvalid: got %0b expected %0b at %0t", d1_a_rvalid, cur_va, $time); end
        checks++; if (d1_b_rvalid !== cur_vb) begin errors++; $display("FAIL d1_b_rvalid: got %0b expected %0b at %0t", d1_b_rvalid, cur_vb, $time); end
        checks++; if (d2_a_rvalid !== prev_va) begin errors++; $display("FAIL d2_a_rvalid: got %0b expected %0b at %0t", d2_a_rvalid, prev_va, $time); end
        checks++; if (d2_b_rvalid !== prev_vb) begin errors++; $display("FAIL d2_b_rvalid: got %0b expected %0b at %0t", d2_b_rvalid, prev_vb, $time); end
        checks++; if (d1_a_rdata !== last1_a) begin errors++; $display("FAIL d1_a_rdata: got %h expected %h at %0t", d1_a_rdata, last1_a, $time); end
        checks++; if (d1_b_rdata !== last1_b) begin errors++; $display("FAIL d1_b_rdata: got %h expected %h at %0t", d1_b_rdata, last1_b, $time); end
        checks++; if (d2_a_rdata !== last2_a) begin errors++; $display("FAIL d2_a_rdata: got %h expected %h at %0t", d2_a_rdata, last2_a, $time); end
        checks++; if (d2_b_rdata !== last2_b) begin errors++; $display("FAIL d2_b_rdata: got %h expected %h at %0t", d2_b_rdata, last2_b, $time); end
    endtask

    task automatic set_a(input logic en, input logic we, input logic [3:0] be,
                         input logic [3:0] addr, input logic [31:0] data);
        a_en = en; a_we = we; a_be = be; a_addr = addr; a_wdata = data;
    endtask

    task automatic set_b(input logic en, input logic we, input logic [3:0] be,
                         input logic [3:0] addr, input logic [31:0] data);
        b_en = en; b_we = we; b_be = be; b_addr = addr; b_wdata = data;
    endtask

    task automatic idle();
        set_a(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        set_b(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        clr_req = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        int n;
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (d1_busy !== 1'b1 || d1_a_rvalid !== 1'b0 || d1_a_rdata !== 32'h0 || d1_coll !== 1'b0) begin
            errors++; $display("FAIL reset_state: busy=%0b rvalid=%0b rdata=%h coll=%0b expected 1/0/0/0", d1_busy, d1_a_rvalid, d1_a_rdata, d1_coll);
        end
        rst = 1'b0;
        n = 0;
        while (d1_busy && n < 40) begin tick(); n++; end
        checks++; if (n != 16) begin errors++; $display("FAIL clear_length: busy lasted %0d cycles, expected 16", n); end
        set_a(1'b1, 1'b0, 4'h0, 4'd5, 32'h0);
        tick();
        idle();
        checks++; if (d1_a_rvalid !== 1'b1 || d1_a_rdata !== 32'h0) begin
            errors++; $display("FAIL read_after_clear: rvalid=%0b rdata=%h expected 1/00000000", d1_a_rvalid, d1_a_rdata);
        end
        tick();
        checks++; if (d1_a_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_one_cycle: got %0b expected 0", d1_a_rvalid); end
    endtask

    task automatic test_byte_write();
        set_a(1'b1, 1'b1, 4'b0101, 4'd3, 32'hAABBCCDD);
        tick();
        idle();
        set_b(1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
        tick();
        idle();
        checks++; if (d1_b_rvalid !== 1'b1 || d1_b_rdata !== 32'h00BB00DD) begin
            errors++; $display("FAIL byte_enable: rvalid=%0b rdata=%h expected 1/00bb00dd", d1_b_rvalid, d1_b_rdata);
        end
    endtask

    task automatic test_collision();
        set_a(1'b1, 1'b1, 4'b0011, 4'd7, 32'h11111111);
        set_b(1'b1, 1'b1, 4'b1111, 4'd7, 32'h22222222);
        tick();
        idle();
        checks++; if (d1_coll !== 1'b1) begin errors++; $display("FAIL coll_pulse: got %0b expected 1", d1_coll); end
        tick();
        checks++; if (d1_coll !== 1'b0) begin errors++; $display("FAIL coll_single: got %0b expected 0", d1_coll); end
        set_a(1'b1, 1'b0, 4'h0, 4'd7, 32'h0);
        tick();
        idle();
        checks++; if (d1_a_rdata !== 32'h22221111) begin errors++; $display("FAIL coll_merge: got %h expected 22221111", d1_a_rdata); end
    endtask

    task automatic test_read_during_write();
        logic [31:0] exp;
`ifdef DPRAM_CLR_FWD_EN
        exp = 32'h00000055;
`else
        exp = 32'h00000000;
`endif
        set_a(1'b1, 1'b0, 4'h0, 4'd9, 32'h0);
        set_b(1'b1, 1'b1, 4'hF, 4'd9, 32'h00000055);
        tick();
        idle();
        checks++; if (d1_a_rvalid !== 1'b1 || d1_a_rdata !== exp) begin
            errors++; $display("FAIL read_during_write: rvalid=%0b rdata=%h expected 1/%h", d1_a_rvalid, d1_a_rdata, exp);
        end
        set_a(1'b1, 1'b0, 4'h0, 4'd9, 32'h0);
        tick();
        idle();
        checks++; if (d1_a_rdata !== 32'h00000055) begin errors++; $display("FAIL write_landed: got %h expected 00000055", d1_a_rdata); end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        checks++; if (d1_busy !== 1'b1) begin errors++; $display("FAIL clr_req_start: busy=%0b expected 1", d1_busy); end
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_a(1'b1, 1'b1, 4'hF, 4'd2, 32'hDEADBEEF);
        n = 0;
        while (d1_busy && n < 40) begin tick(); idle(); n++; end
        checks++; if (n != 16) begin errors++; $display("FAIL restart_length: busy lasted %0d cycles, expected 16", n); end
        set_a(1'b1, 1'b0, 4'h0, 4'd2, 32'h0);
        tick();
        idle();
        checks++; if (d1_a_rdata !== INIT) begin errors++; $display("FAIL write_during_clear: got %h expected %h", d1_a_rdata, INIT); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        for (int k = 0; k < 4; k++) begin
            vals[k] = $urandom;
            set_a(1'b1, 1'b1, 4'hF, 4'(10 + k), vals[k]);
            tick();
        end
        idle();
        for (int t = 0; t < 6; t++) begin
            if (t < 4) set_b(1'b1, 1'b0, 4'h0, 4'(10 + t), 32'h0);
            else       idle();
            tick();
            checks++; if (d2_b_rvalid !== (t >= 1 && t <= 4)) begin
                errors++; $display("FAIL lat2_valid[%0d]: got %0b expected %0b", t, d2_b_rvalid, (t >= 1 && t <= 4));
            end
            if (t >= 1 && t <= 4) begin
                checks++; if (d2_b_rdata !== vals[t-1]) begin errors++; $display("FAIL lat2_data[%0d]: got %h expected %h", t, d2_b_rdata, vals[t-1]); end
            end
            if (t <= 3) begin
                checks++; if (d1_b_rvalid !== 1'b1 || d1_b_rdata !== vals[t]) begin
                    errors++; $display("FAIL lat1_data[%0d]: rvalid=%0b rdata=%h expected 1/%h", t, d1_b_rvalid, d1_b_rdata, vals[t]);
                end
            end
        end
        idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            set_a(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom_range(0, 5)), $urandom);
            set_b(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom_range(0, 5)), $urandom);
            clr_req = ($urandom_range(0, 79) == 0);
            rst     = ($urandom_range(0, 199) == 0);
            tick();
        end
        idle();
        rst = 1'b0;
        repeat (40) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        test_reset();
        test_byte_write();
        test_collision();
        test_read_during_write();
        test_reset_mid_clear();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpram_clr.md
DPRAM_CLR -- requirements
Module: dpram_clr

Interface
REQ-001 SHALL have parameter DWIDTH, default 32: data width in bits, a multiple of 8.
REQ-002 SHALL have parameter AWIDTH, default 10: address width; DEPTH = 2**AWIDTH.
REQ-003 SHALL have parameter RDLAT, default 1: read latency in cycles, legal values 1 or 2.
REQ-004 SHALL have parameter INIT_VAL, default 0: DWIDTH-bit value written to every word by the clear engine.
REQ-005 SHALL have port clk, input, 1 bit: single clock; the block has one clock and all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port clr_req, input, 1 bit: single-cycle request to start a memory clear.
REQ-008 SHALL have port clr_busy, output, 1 bit: clear engine active.
REQ-009 SHALL have port a_en, input, 1 bit: port A access strobe.
REQ-010 SHALL have port a_we, input, 1 bit: port A write when high, read when low.
REQ-011 SHALL have port a_be, input, DWIDTH/8 bits: port A byte enables.
REQ-012 SHALL have port a_addr, input, AWIDTH bits: port A address.
REQ-013 SHALL have port a_wdata, input, DWIDTH bits: port A write data.
REQ-014 SHALL have port a_rdata, output, DWIDTH bits: port A read data.
REQ-015 SHALL have port a_rvalid, output, 1 bit: port A read data valid.
REQ-016 SHALL have ports b_en, b_we, b_be, b_addr, b_wdata, b_rdata and b_rvalid, with the same directions, widths and meanings as the port A signals.
REQ-017 SHALL have port coll, output, 1 bit: write-write collision pulse.

Function
REQ-018 The clear engine SHALL have two states: IDLE and CLEAR.
REQ-019 In CLEAR, a counter SHALL step from 0 to DEPTH-1, writing INIT_VAL to one word per cycle; the engine then returns to IDLE.
REQ-020 clr_busy SHALL be high exactly while the engine is in CLEAR; a full clear takes DEPTH cycles.
REQ-021 clr_req in IDLE SHALL move the engine to CLEAR on the next edge; clr_req in CLEAR SHALL be ignored.
REQ-022 While clr_busy is high, all port accesses SHALL be ignored: no write occurs and no rvalid is generated.
REQ-023 An access on a port is accepted when the port's en is high and clr_busy is low.
REQ-024 An accepted write SHALL update only the bytes whose be bit is high; other bytes keep their contents.
REQ-025 An accepted read SHALL assert that port's rvalid for exactly one cycle, RDLAT cycles after acceptance, with the matching rdata.
REQ-026 Back-to-back reads SHALL be fully pipelined, giving one result per cycle per port.
REQ-027 rdata SHALL hold its last value when rvalid is low; writes SHALL NOT generate rvalid.
REQ-028 If both ports write the same address in the same cycle: for bytes enabled on port A, port A data SHALL win; bytes enabled only on B SHALL take B data.
REQ-029 In the write-write case of REQ-028, coll SHALL pulse high for one cycle, on the cycle after the collision.
REQ-030 A read on one port while the other port writes the same address in the same cycle SHALL be handled as defined in Configuration.

Reset
REQ-031 While rst is high: a_rdata = b_rdata = 0, a_rvalid = b_rvalid = 0, coll = 0, the read pipelines are flushed, and the clear counter is 0.
REQ-032 While rst is high, the engine SHALL be held in CLEAR with clr_busy = 1.
REQ-033 After rst deasserts, the clear SHALL run to completion automatically.
REQ-034 Reset asserted mid-clear SHALL restart the clear from address 0.
REQ-035 Reset SHALL drop in-flight reads: no rvalid for reads accepted before reset.

Configuration
REQ-036 The macro DPRAM_CLR_FWD_EN SHALL control cross-port forwarding.
REQ-037 With DPRAM_CLR_FWD_EN defined, a cross-port read-during-write to the same address SHALL return the newly written data, merged per byte with the old contents according to be.
REQ-038 Without DPRAM_CLR_FWD_EN, the same case SHALL return the old contents, and no forwarding logic SHALL be present.

Verification (DWIDTH=32, AWIDTH=4, RDLAT=1, INIT_VAL=0 unless stated)
REQ-039 Reset then release -> clr_busy high for 16 cycles after release; a subsequent read of address 5 -> rdata 0x00000000 with rvalid one cycle later.
REQ-040 Port A write to address 3 with data 0xAABBCCDD, be 0101 -> port B read of address 3 returns 0x00BB00DD.
REQ-041 Same-cycle writes to address 7, A = 0x11111111 with be 0011 and B = 0x22222222 with be 1111 -> coll pulses once; a following read returns 0x22221111.
REQ-042 Address 9 holds 0; A reads 9 while B writes 0x55 to 9 -> a_rdata 0x00000000 without DPRAM_CLR_FWD_EN, 0x00000055 with it.
REQ-043 rst asserted at clear count 8 -> clear restarts; clr_busy stays high for 16 cycles after release; a port write attempted during the clear -> ignored and the address reads INIT_VAL.
REQ-044 RDLAT=2, reads issued on 4 consecutive cycles -> 4 consecutive rvalid pulses beginning 2 cycles after the first read, with the data in issue order.
